// File: rtl/lens_param_if.sv
// Control/status bundle between the button front end, the lens parameter
// controller and the lens-filter image reader.
interface lens_param_if #(
   parameter int MAX_LENS = 8
);
   logic                         frame_start;
   logic                         sw0_edit_mode;
   logic [1:0]                   param_sel;
   logic                         btn_up;
   logic                         btn_down;
   logic                         btn_left;
   logic                         btn_right;
   logic                         btn_place;
   logic                         btn_undo;
   logic                         btn_clear;

   logic [8:0]                   current_center_x;
   logic [7:0]                   current_center_y;
   logic [7:0]                   current_R;
   logic [7:0]                   current_K;
   logic                         preview_enable;
   logic [2:0]                   lens_count;
   logic [MAX_LENS-1:0][8:0]     lens_center_x;
   logic [MAX_LENS-1:0][7:0]     lens_center_y;
   logic [MAX_LENS-1:0][7:0]     lens_R;
   logic [MAX_LENS-1:0][7:0]     lens_K;
   logic                         full;
   logic                         busy;

   modport master (
      output frame_start, sw0_edit_mode, param_sel,
             btn_up, btn_down, btn_left, btn_right, btn_place, btn_undo, btn_clear,
      input  current_center_x, current_center_y, current_R, current_K,
             preview_enable, lens_count, lens_center_x, lens_center_y, lens_R, lens_K,
             full, busy
   );

   modport slave (
      input  frame_start, sw0_edit_mode, param_sel,
             btn_up, btn_down, btn_left, btn_right, btn_place, btn_undo, btn_clear,
      output current_center_x, current_center_y, current_R, current_K,
             preview_enable, lens_count, lens_center_x, lens_center_y, lens_R, lens_K,
             full, busy
   );
endinterface

// File: rtl/lens_param_ctrl.sv
// Lens parameter controller: button edits on a working lens set, stored lens
// table, and a frame-synchronous copy to the published set seen by the reader.
//
// state  | meaning
// VIEW   | buttons ignored, preview off
// EDIT   | buttons edit working lens / table, preview on
// COMMIT | one cycle: store working lens at entry[count], count+1
// CLEAR  | MAX_LENS cycles: zero entry[idx] per cycle, then count=0
module lens_param_ctrl #(
   parameter int IMG_WIDTH     = 320,
   parameter int IMG_HEIGHT    = 240,
   parameter int MAX_LENS      = 8,
   parameter int STEP_XY       = 4,
   parameter int R_MIN         = 8,
   parameter int R_MAX         = 120,
   parameter int R_DEFAULT     = 40,
   parameter int R_STEP        = 4,
   parameter int K_MIN         = 8,
   parameter int K_MAX         = 255,
   parameter int K_DEFAULT     = 64,
   parameter int K_STEP        = 8,
   parameter int REPEAT_FRAMES = 6
) (
   input logic        clk,
   input logic        reset,
   lens_param_if.slave bus
);
   localparam int CW = $clog2(MAX_LENS);
   localparam int RW = $clog2(REPEAT_FRAMES) + 1;
   localparam logic [CW-1:0] CNT_FULL = CW'(MAX_LENS - 1);
   localparam logic [RW-1:0] REP_LOAD = RW'(REPEAT_FRAMES - 1);
   localparam logic signed [9:0] ZERO  = 10'sd0;
   localparam logic signed [9:0] X_MAX = 10'(IMG_WIDTH - 1);
   localparam logic signed [9:0] Y_MAX = 10'(IMG_HEIGHT - 1);
   localparam logic signed [9:0] R_LO  = 10'(R_MIN);
   localparam logic signed [9:0] R_HI  = 10'(R_MAX);
   localparam logic signed [9:0] K_LO  = 10'(K_MIN);
   localparam logic signed [9:0] K_HI  = 10'(K_MAX);
   localparam logic signed [9:0] S_XY  = 10'(STEP_XY);
   localparam logic signed [9:0] S_R   = 10'(R_STEP);
   localparam logic signed [9:0] S_K   = 10'(K_STEP);

   typedef enum logic [1:0] {VIEW, EDIT, COMMIT, CLEAR} state_t;

   function automatic logic [9:0] clamp(input logic signed [9:0] v,
                                        input logic signed [9:0] lo,
                                        input logic signed [9:0] hi);
      if (v < lo) return lo;
      if (v > hi) return hi;
      return v;
   endfunction

   state_t                   state;
   logic [8:0]               w_x;
   logic [7:0]               w_y, w_r, w_k;
   logic                     w_pv;
   logic [CW-1:0]            w_cnt, idx, cnt_m1;
   logic [MAX_LENS-1:0][8:0] t_x;
   logic [MAX_LENS-1:0][7:0] t_y, t_r, t_k;
   logic                     pend;

   logic [8:0]               p_x;
   logic [7:0]               p_y, p_r, p_k;
   logic                     p_pv;
   logic [CW-1:0]            p_cnt;
   logic [MAX_LENS-1:0][8:0] p_tx;
   logic [MAX_LENS-1:0][7:0] p_ty, p_tr, p_tk;

   // bit order: up, down, left, right, undo, place, clear
   logic [6:0]    btn, btn_q, rise;
   logic [RW-1:0] rep_cnt [4];
   logic [3:0]    dir;
   logic signed [9:0] d_h, d_v, d_r, d_k;

   assign btn    = {bus.btn_clear, bus.btn_place, bus.btn_undo, bus.btn_right,
                    bus.btn_left, bus.btn_down, bus.btn_up};
   assign rise   = btn & ~btn_q;
   assign cnt_m1 = w_cnt - 1'b1;

   // Auto-repeat: reload while released, fire when the held count reaches zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) rep_cnt[i] <= REP_LOAD;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (!btn[i])
               rep_cnt[i] <= REP_LOAD;
            else if (bus.frame_start)
               rep_cnt[i] <= (rep_cnt[i] == '0) ? REP_LOAD : rep_cnt[i] - 1'b1;
         end
      end
   end

   always_comb begin
      dir = '0;
      for (int i = 0; i < 4; i++)
         dir[i] = rise[i] | (btn[i] & bus.frame_start & (rep_cnt[i] == '0));
      d_h = (dir[3] ? S_XY : ZERO) - (dir[2] ? S_XY : ZERO);
      d_v = (dir[1] ? S_XY : ZERO) - (dir[0] ? S_XY : ZERO);
      d_r = (dir[0] ? S_R  : ZERO) - (dir[1] ? S_R  : ZERO);
      d_k = (dir[0] ? S_K  : ZERO) - (dir[1] ? S_K  : ZERO);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= VIEW;
         btn_q <= '0;
         w_x   <= 9'(IMG_WIDTH / 2);
         w_y   <= 8'(IMG_HEIGHT / 2);
         w_r   <= 8'(R_DEFAULT);
         w_k   <= 8'(K_DEFAULT);
         w_pv  <= 1'b0;
         w_cnt <= '0;
         idx   <= '0;
         t_x   <= '0;
         t_y   <= '0;
         t_r   <= '0;
         t_k   <= '0;
         pend  <= 1'b0;
         p_x   <= 9'(IMG_WIDTH / 2);
         p_y   <= 8'(IMG_HEIGHT / 2);
         p_r   <= 8'(R_DEFAULT);
         p_k   <= 8'(K_DEFAULT);
         p_pv  <= 1'b0;
         p_cnt <= '0;
         p_tx  <= '0;
         p_ty  <= '0;
         p_tr  <= '0;
         p_tk  <= '0;
      end else begin
         btn_q <= btn;

         // The table is being wiped during CLEAR; hold the publish until it is done.
         if (state != CLEAR && (bus.frame_start || pend)) begin
            p_x   <= w_x;
            p_y   <= w_y;
            p_r   <= w_r;
            p_k   <= w_k;
            p_pv  <= w_pv;
            p_cnt <= w_cnt;
            p_tx  <= t_x;
            p_ty  <= t_y;
            p_tr  <= t_r;
            p_tk  <= t_k;
            pend  <= 1'b0;
         end else if (state == CLEAR && bus.frame_start) begin
            pend <= 1'b1;
         end

         case (state)
            VIEW: begin
               w_pv <= 1'b0;
               if (bus.sw0_edit_mode) state <= EDIT;
            end
            EDIT: begin
               w_pv <= 1'b1;
               if (!bus.sw0_edit_mode) begin
                  state <= VIEW;
               end else if (rise[6]) begin
                  state <= CLEAR;
                  idx   <= '0;
               end else if (rise[5]) begin
                  if (w_cnt != CNT_FULL) state <= COMMIT;
               end else if (rise[4]) begin
                  if (w_cnt != '0) begin
                     t_x[cnt_m1] <= '0;
                     t_y[cnt_m1] <= '0;
                     t_r[cnt_m1] <= '0;
                     t_k[cnt_m1] <= '0;
                     w_cnt       <= cnt_m1;
                  end
               end else begin
                  case (bus.param_sel)
                     2'b01:   w_r <= 8'(clamp($signed({2'b00, w_r}) + d_r, R_LO, R_HI));
                     2'b10:   w_k <= 8'(clamp($signed({2'b00, w_k}) + d_k, K_LO, K_HI));
                     default: begin
                        w_x <= 9'(clamp($signed({1'b0, w_x}) + d_h, ZERO, X_MAX));
                        w_y <= 8'(clamp($signed({2'b00, w_y}) + d_v, ZERO, Y_MAX));
                     end
                  endcase
               end
            end
            COMMIT: begin
               t_x[w_cnt] <= w_x;
               t_y[w_cnt] <= w_y;
               t_r[w_cnt] <= w_r;
               t_k[w_cnt] <= w_k;
               w_cnt      <= w_cnt + 1'b1;
               state      <= bus.sw0_edit_mode ? EDIT : VIEW;
            end
            CLEAR: begin
               t_x[idx] <= '0;
               t_y[idx] <= '0;
               t_r[idx] <= '0;
               t_k[idx] <= '0;
               if (idx == CNT_FULL) begin
                  w_cnt <= '0;
                  state <= bus.sw0_edit_mode ? EDIT : VIEW;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            default: state <= VIEW;
         endcase
      end
   end

   assign bus.current_center_x = p_x;
   assign bus.current_center_y = p_y;
   assign bus.current_R        = p_r;
   assign bus.current_K        = p_k;
   assign bus.preview_enable   = p_pv;
   assign bus.lens_count       = 3'(p_cnt);
   assign bus.lens_center_x    = p_tx;
   assign bus.lens_center_y    = p_ty;
   assign bus.lens_R           = p_tr;
   assign bus.lens_K           = p_tk;
   assign bus.full             = (w_cnt == CNT_FULL);
   assign bus.busy             = (state == COMMIT) || (state == CLEAR);
endmodule

// File: tb/tb_lens_param_ctrl.sv
// Bench for lens_param_ctrl: per-cycle comparison against an integer model of
// the lens editor, a vector table of single edits, and directed corner sequences.
module tb_lens_param_ctrl;
   logic       clk = 1'b0;
   logic       reset;
   logic       fs, sw0;
   logic [1:0] sel;
   logic [6:0] btns;   // up, down, left, right, undo, place, clear

   always #5 clk = ~clk;

   lens_param_if bus();
   assign bus.frame_start   = fs;
   assign bus.sw0_edit_mode = sw0;
   assign bus.param_sel     = sel;
   assign bus.btn_up        = btns[0];
   assign bus.btn_down      = btns[1];
   assign bus.btn_left      = btns[2];
   assign bus.btn_right     = btns[3];
   assign bus.btn_undo      = btns[4];
   assign bus.btn_place     = btns[5];
   assign bus.btn_clear     = btns[6];

   lens_param_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

   int n_tests = 0;
   int n_fail  = 0;

   localparam logic [6:0] B_UP = 7'h01, B_DN = 7'h02, B_LF = 7'h04, B_RT = 7'h08,
                          B_UNDO = 7'h10, B_PLACE = 7'h20, B_CLR = 7'h40;

   // Model: mode 0 view, 1 edit, 2 commit, 3 clear.
   int m_mode, m_x, m_y, m_r, m_k, m_pv, m_cnt, m_idx, m_pend;
   int m_tx[8], m_ty[8], m_tr[8], m_tk[8];
   int p_x, p_y, p_r, p_k, p_pv, p_cnt;
   int p_tx[8], p_ty[8], p_tr[8], p_tk[8];
   bit m_prev[7];
   int m_held[4];

   function automatic int clampi(int v, int lo, int hi);
      return (v < lo) ? lo : (v > hi) ? hi : v;
   endfunction

   function automatic void model_reset();
      m_mode = 0; m_x = 160; m_y = 120; m_r = 40; m_k = 64; m_pv = 0;
      m_cnt = 0; m_idx = 0; m_pend = 0;
      p_x = 160; p_y = 120; p_r = 40; p_k = 64; p_pv = 0; p_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         m_tx[i] = 0; m_ty[i] = 0; m_tr[i] = 0; m_tk[i] = 0;
         p_tx[i] = 0; p_ty[i] = 0; p_tr[i] = 0; p_tk[i] = 0;
      end
      for (int i = 0; i < 7; i++) m_prev[i] = 0;
      for (int i = 0; i < 4; i++) m_held[i] = 0;
   endfunction

   function automatic void model_step();
      bit rise[7];
      int ev[4];
      int h, v;
      for (int i = 0; i < 7; i++) rise[i] = btns[i] && !m_prev[i];
      for (int i = 0; i < 4; i++)
         ev[i] = (rise[i] || (btns[i] && fs && ((m_held[i] + 1) % 6 == 0))) ? 1 : 0;
      if (m_mode != 3 && (fs || m_pend != 0)) begin
         p_x = m_x; p_y = m_y; p_r = m_r; p_k = m_k; p_pv = m_pv; p_cnt = m_cnt;
         p_tx = m_tx; p_ty = m_ty; p_tr = m_tr; p_tk = m_tk;
         m_pend = 0;
      end else if (m_mode == 3 && fs) begin
         m_pend = 1;
      end
      case (m_mode)
         0: begin
            m_pv = 0;
            if (sw0) m_mode = 1;
         end
         1: begin
            m_pv = 1;
            if (!sw0) m_mode = 0;
            else if (rise[6]) begin m_mode = 3; m_idx = 0; end
            else if (rise[5]) begin if (m_cnt < 7) m_mode = 2; end
            else if (rise[4]) begin
               if (m_cnt > 0) begin
                  m_cnt--;
                  m_tx[m_cnt] = 0; m_ty[m_cnt] = 0; m_tr[m_cnt] = 0; m_tk[m_cnt] = 0;
               end
            end else begin
               v = ev[0] - ev[1];
               h = ev[3] - ev[2];
               if (sel == 2'd1)      m_r = clampi(m_r + 4 * v, 8, 120);
               else if (sel == 2'd2) m_k = clampi(m_k + 8 * v, 8, 255);
               else begin
                  m_x = clampi(m_x + 4 * h, 0, 319);
                  m_y = clampi(m_y - 4 * v, 0, 239);
               end
            end
         end
         2: begin
            m_tx[m_cnt] = m_x; m_ty[m_cnt] = m_y; m_tr[m_cnt] = m_r; m_tk[m_cnt] = m_k;
            m_cnt++;
            m_mode = sw0 ? 1 : 0;
         end
         default: begin
            m_tx[m_idx] = 0; m_ty[m_idx] = 0; m_tr[m_idx] = 0; m_tk[m_idx] = 0;
            if (m_idx == 7) begin m_cnt = 0; m_mode = sw0 ? 1 : 0; end
            else m_idx++;
         end
      endcase
      for (int i = 0; i < 7; i++) m_prev[i] = btns[i];
      for (int i = 0; i < 4; i++)
         if (!btns[i]) m_held[i] = 0;
         else if (fs) m_held[i]++;
   endfunction

   task automatic chk(input string name, input logic [299:0] act, input logic [299:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_i(input string name, input int act, input int exp);
      chk(name, 300'(act), 300'(exp));
   endtask

   task automatic check_all();
      logic [299:0] a, e;
      a = '0; e = '0;
      a[38:0] = {bus.current_center_x, bus.current_center_y, bus.current_R, bus.current_K,
                 bus.preview_enable, bus.lens_count, bus.full, bus.busy};
      e[38:0] = {9'(p_x), 8'(p_y), 8'(p_r), 8'(p_k), 1'(p_pv), 3'(p_cnt),
                 1'(m_cnt == 7), 1'(m_mode >= 2)};
      chk("model_scalars", a, e);
      a = '0; e = '0;
      for (int i = 0; i < 8; i++) begin
         a[i*33 +: 33] = {bus.lens_center_x[i], bus.lens_center_y[i], bus.lens_R[i], bus.lens_K[i]};
         e[i*33 +: 33] = {9'(p_tx[i]), 8'(p_ty[i]), 8'(p_tr[i]), 8'(p_tk[i])};
      end
      chk("model_table", a, e);
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic press(input logic [6:0] b);
      btns = b; tick();
      btns = '0; tick();
   endtask

   task automatic frame();
      fs = 1'b1; tick();
      fs = 1'b0; tick();
   endtask

   typedef struct {
      logic [1:0] sel;
      logic [3:0] dirs;   // right, left, down, up
      int         x, y, r, k;
   } vec_t;
   vec_t vecs[12];

   initial begin
      vecs[0]  = '{2'd0, 4'b1000, 164, 120, 40, 64};
      vecs[1]  = '{2'd0, 4'b0010, 164, 124, 40, 64};
      vecs[2]  = '{2'd0, 4'b0001, 164, 120, 40, 64};
      vecs[3]  = '{2'd0, 4'b0100, 160, 120, 40, 64};
      vecs[4]  = '{2'd1, 4'b0001, 160, 120, 44, 64};
      vecs[5]  = '{2'd1, 4'b0010, 160, 120, 40, 64};
      vecs[6]  = '{2'd1, 4'b0100, 160, 120, 40, 64};
      vecs[7]  = '{2'd2, 4'b0001, 160, 120, 40, 72};
      vecs[8]  = '{2'd2, 4'b0010, 160, 120, 40, 64};
      vecs[9]  = '{2'd3, 4'b1000, 164, 120, 40, 64};
      vecs[10] = '{2'd0, 4'b1100, 164, 120, 40, 64};
      vecs[11] = '{2'd2, 4'b0011, 164, 120, 40, 64};

      fs = 0; sw0 = 0; sel = 0; btns = '0;
      reset = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk_i("reset_x", bus.current_center_x, 160);
      chk_i("reset_y", bus.current_center_y, 120);
      chk_i("reset_R", bus.current_R, 40);
      chk_i("reset_K", bus.current_K, 64);
      chk_i("reset_count", bus.lens_count, 0);
      check_all();
      reset = 1'b0;

      sw0 = 1'b1; tick(); tick();

      for (int i = 0; i < 12; i++) begin
         sel  = vecs[i].sel;
         btns = {3'b000, vecs[i].dirs};
         tick();
         btns = '0;
         tick();
         chk_i("vec_x_before_frame", bus.current_center_x, (i == 0) ? 160 : vecs[i-1].x);
         frame();
         chk_i("vec_x", bus.current_center_x, vecs[i].x);
         chk_i("vec_y", bus.current_center_y, vecs[i].y);
         chk_i("vec_R", bus.current_R, vecs[i].r);
         chk_i("vec_K", bus.current_K, vecs[i].k);
      end

      // Walk x down to 8, then hold left: step at press, repeat on the 6th frame.
      sel = 2'd0;
      for (int i = 0; i < 39; i++) press(B_LF);
      frame();
      chk_i("hold_start_x", bus.current_center_x, 8);
      btns = B_LF; tick(); tick(); tick();
      for (int f = 1; f <= 20; f++) begin
         fs = 1'b1; tick();
         fs = 1'b0; tick(); tick();
         chk_i("hold_x", bus.current_center_x, (f <= 6) ? 4 : 0);
      end
      btns = '0; tick();

      // Fill the table with distinct radii.
      sel = 2'd1;
      for (int i = 0; i < 7; i++) begin
         press(B_UP);
         press(B_PLACE);
      end
      frame();
      chk_i("fill_count", bus.lens_count, 7);
      chk_i("fill_full", bus.full, 1);
      chk_i("fill_R0", bus.lens_R[0], 44);
      chk_i("fill_R6", bus.lens_R[6], 68);
      press(B_PLACE);
      frame();
      chk_i("place_when_full", bus.lens_count, 7);
      press(B_UNDO);
      frame();
      chk_i("undo_count", bus.lens_count, 6);
      chk_i("undo_full", bus.full, 0);
      chk_i("undo_R6", bus.lens_R[6], 0);
      chk_i("undo_X6", bus.lens_center_x[6], 0);
      repeat (3) press(B_UNDO);
      frame();
      chk_i("undo3_count", bus.lens_count, 3);

      // Clear and place together: clear wins, publish deferred past the wipe.
      btns = B_CLR | B_PLACE; tick();
      btns = '0;
      chk_i("clear_busy", bus.busy, 1);
      for (int k = 1; k <= 8; k++) begin
         fs = (k == 3);
         tick();
         chk_i("clear_busy", bus.busy, (k < 8) ? 1 : 0);
         chk_i("clear_count_held", bus.lens_count, 3);
      end
      fs = 1'b0; tick();
      chk_i("clear_count_published", bus.lens_count, 0);
      chk_i("clear_R0", bus.lens_R[0], 0);

      // VIEW mode ignores buttons and drops preview.
      sw0 = 1'b0; tick();
      sel = 2'd0;
      press(B_RT);
      press(B_PLACE);
      frame();
      chk_i("view_preview", bus.preview_enable, 0);
      chk_i("view_x", bus.current_center_x, 0);
      chk_i("view_count", bus.lens_count, 0);

      // Radius saturates at the upper limit.
      sw0 = 1'b1; tick(); tick();
      sel = 2'd1;
      for (int i = 0; i < 16; i++) press(B_UP);
      frame();
      chk_i("radius_max", bus.current_R, 120);
      chk_i("edit_preview", bus.preview_enable, 1);
      press(B_UP);
      frame();
      chk_i("radius_stays_max", bus.current_R, 120);

      // Random traffic against the model.
      for (int c = 0; c < 4000; c++) begin
         for (int i = 0; i < 6; i++)
            if ($urandom_range(0, 7) == 0) btns[i] = ~btns[i];
         if ($urandom_range(0, 63) == 0) btns[6] = ~btns[6];
         fs = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 149) == 0) sw0 = ~sw0;
         if ($urandom_range(0, 39) == 0) sel = 2'($urandom_range(0, 3));
         tick();
      end

      // Reset asserted in the middle of CLEAR.
      fs = 1'b0; btns = '0; sw0 = 1'b1;
      repeat (10) tick();
      btns = B_CLR; tick();
      btns = '0; tick(); tick();
      chk_i("midclear_busy", bus.busy, 1);
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      check_all();
      @(posedge clk);
      #1;
      chk_i("rst_clear_x", bus.current_center_x, 160);
      chk_i("rst_clear_y", bus.current_center_y, 120);
      chk_i("rst_clear_R", bus.current_R, 40);
      chk_i("rst_clear_K", bus.current_K, 64);
      chk_i("rst_clear_count", bus.lens_count, 0);
      chk_i("rst_clear_busy", bus.busy, 0);
      chk_i("rst_clear_full", bus.full, 0);
      chk_i("rst_clear_preview", bus.preview_enable, 0);
      check_all();
      reset = 1'b0;
      sw0 = 1'b0;
      repeat (4) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
